// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM/WB control bit positions and access-size encodings.
package mips_pkg;

  // MEM control bus layout
  localparam int unsigned MEMREAD_BIT  = 4;
  localparam int unsigned MEMWRITE_BIT = 3;
  localparam int unsigned SIZE_MSB     = 2;
  localparam int unsigned SIZE_LSB     = 1;
  localparam int unsigned UNSIGNED_BIT = 0;

  // Access size encodings; 2'b10 is reserved and treated as a word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // WB control bus layout
  localparam int unsigned REGWRITE_BIT = 1;
  localparam int unsigned MEMTOREG_BIT = 0;

  // Natural alignment check for a given access size and byte lane
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lane[0];
      default:   mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enable write on the clock edge, combinational word read.
// Optional asynchronous debug read port enabled by MEM_DEBUG_PORT_EN.
module data_memory #(
  parameter int unsigned LEN         = 32,
  parameter int unsigned NB_ADDR_MEM = 10
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [LEN/8-1:0]       i_be,
  input  logic [NB_ADDR_MEM-1:0] i_addr,
  input  logic [LEN-1:0]         i_wdata,
  output logic [LEN-1:0]         o_rdata
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR_MEM-1:0] i_debug_addr,
  output logic [LEN-1:0]         o_debug_data
`endif
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR_MEM;
  localparam int unsigned NB_BE = LEN / 8;

  logic [LEN-1:0] mem_q [DEPTH];
  logic [LEN-1:0] word_d;

  // Read the addressed word and merge the enabled store lanes into it
  always_comb begin
    o_rdata = mem_q[i_addr];
    word_d  = o_rdata;
    for (int b = 0; b < NB_BE; b++) begin
      if (i_be[b]) begin
        word_d[b*8 +: 8] = i_wdata[b*8 +: 8];
      end
    end
  end

  // Memory array update; contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= word_d;
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  // Debug view reads the array before the edge, so a coinciding store shows old data
  assign o_debug_data = mem_q[i_debug_addr];
`endif

endmodule

// File: rtl/tl_memory_access.sv
// MIPS MEM stage: data memory access (LB/LBU/LH/LHU/LW, SB/SH/SW) plus the MEM/WB register.
// Defining MEM_DEBUG_PORT_EN adds an asynchronous debug word-read port.
module tl_memory_access
  import mips_pkg::*;
#(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned NB_CTRL_MEM          = 5,
  parameter int unsigned NB_CTRL_WB           = 2,
  parameter int unsigned NB_ADDRESS_REGISTROS = 5,
  parameter int unsigned NB_ADDR_MEM          = 10
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [LEN-1:0]                  i_result_alu,
  input  logic [LEN-1:0]                  i_write_data_mem,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_result_alu,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic                            o_misaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
  output logic [LEN-1:0]                  o_debug_data
`endif
);

  localparam int unsigned NB_BE = LEN / 8;

  logic                   mem_read;
  logic                   mem_write;
  logic                   is_unsigned;
  logic [1:0]             size;
  logic [1:0]             lane;
  logic [NB_ADDR_MEM-1:0] word_idx;
  logic                   misaligned;
  logic                   mem_we;
  logic [NB_BE-1:0]       mem_be;
  logic [LEN-1:0]         mem_wdata;
  logic [LEN-1:0]         mem_rdata;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [LEN-1:0]         load_ext;

  logic [LEN-1:0]                  read_data_d, read_data_q;
  logic [LEN-1:0]                  result_alu_d, result_alu_q;
  logic [NB_CTRL_WB-1:0]           ctrl_wb_d, ctrl_wb_q;
  logic [NB_ADDRESS_REGISTROS-1:0] write_reg_d, write_reg_q;
  logic                            misaligned_d, misaligned_q;

  // Decode the access and build the store lanes
  always_comb begin
    mem_read    = i_ctrl_mem[MEMREAD_BIT];
    mem_write   = i_ctrl_mem[MEMWRITE_BIT];
    is_unsigned = i_ctrl_mem[UNSIGNED_BIT];
    size        = i_ctrl_mem[SIZE_MSB:SIZE_LSB];
    lane        = i_result_alu[1:0];
    word_idx    = i_result_alu[NB_ADDR_MEM+1:2];
    misaligned  = (mem_read | mem_write) & is_misaligned(size, lane);
    // Reset and stall both drop the store
    mem_we      = i_enable & ~i_reset & mem_write & ~misaligned;

    case (size)
      SIZE_BYTE: begin
        mem_be    = NB_BE'(1) << lane;
        mem_wdata = {(LEN/8){i_write_data_mem[7:0]}};
      end
      SIZE_HALF: begin
        mem_be    = NB_BE'(2'b11) << {lane[1], 1'b0};
        mem_wdata = {(LEN/16){i_write_data_mem[15:0]}};
      end
      default: begin
        mem_be    = '1;
        mem_wdata = i_write_data_mem;
      end
    endcase
  end

  data_memory #(
    .LEN         (LEN),
    .NB_ADDR_MEM (NB_ADDR_MEM)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_we         (mem_we),
    .i_be         (mem_be),
    .i_addr       (word_idx),
    .i_wdata      (mem_wdata),
    .o_rdata      (mem_rdata)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data)
`endif
  );

  // Lane selection and sign/zero extension of load data
  always_comb begin
    byte_sel = mem_rdata[{lane, 3'b000} +: 8];
    half_sel = mem_rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: load_ext = is_unsigned ? {{(LEN-8){1'b0}}, byte_sel}
                                        : {{(LEN-8){byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_ext = is_unsigned ? {{(LEN-16){1'b0}}, half_sel}
                                        : {{(LEN-16){half_sel[15]}}, half_sel};
      default:   load_ext = mem_rdata;
    endcase
  end

  // MEM/WB next state: advance on enable, otherwise hold
  always_comb begin
    read_data_d  = read_data_q;
    result_alu_d = result_alu_q;
    ctrl_wb_d    = ctrl_wb_q;
    write_reg_d  = write_reg_q;
    misaligned_d = misaligned_q;
    if (i_enable) begin
      read_data_d  = (mem_read && !misaligned) ? load_ext : '0;
      result_alu_d = i_result_alu;
      ctrl_wb_d    = i_ctrl_wb;
      write_reg_d  = i_write_reg;
      misaligned_d = misaligned;
    end
  end

  // MEM/WB register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      read_data_q  <= '0;
      result_alu_q <= '0;
      ctrl_wb_q    <= '0;
      write_reg_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      result_alu_q <= result_alu_d;
      ctrl_wb_q    <= ctrl_wb_d;
      write_reg_q  <= write_reg_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_result_alu = result_alu_q;
  assign o_ctrl_wb    = ctrl_wb_q;
  assign o_write_reg  = write_reg_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_tl_memory_access.sv
// Bench for tl_memory_access: byte-addressed reference model, per-cycle compare, directed
// literal checks and randomized traffic.
module tb_tl_memory_access;

  localparam int LEN         = 32;
  localparam int NB_CTRL_MEM = 5;
  localparam int NB_CTRL_WB  = 2;
  localparam int NB_REG      = 5;
  localparam int NB_ADDR_MEM = 10;
  localparam int MEM_BYTES   = 4 << NB_ADDR_MEM;

  localparam logic [4:0] C_NOP = 5'b00000;
  localparam logic [4:0] C_LB  = 5'b10000;
  localparam logic [4:0] C_LBU = 5'b10001;
  localparam logic [4:0] C_LH  = 5'b10010;
  localparam logic [4:0] C_LHU = 5'b10011;
  localparam logic [4:0] C_LW  = 5'b10110;
  localparam logic [4:0] C_SB  = 5'b01000;
  localparam logic [4:0] C_SH  = 5'b01010;
  localparam logic [4:0] C_SW  = 5'b01110;

  logic                   clk;
  logic                   rst;
  logic                   en;
  logic [NB_CTRL_MEM-1:0] ctrl_mem;
  logic [NB_CTRL_WB-1:0]  ctrl_wb;
  logic [LEN-1:0]         alu;
  logic [LEN-1:0]         wdata;
  logic [NB_REG-1:0]      wreg;
  logic [LEN-1:0]         o_read_data;
  logic [LEN-1:0]         o_result_alu;
  logic [NB_CTRL_WB-1:0]  o_ctrl_wb;
  logic [NB_REG-1:0]      o_write_reg;
  logic                   o_misaligned;

  tl_memory_access #(
    .LEN                  (LEN),
    .NB_CTRL_MEM          (NB_CTRL_MEM),
    .NB_CTRL_WB           (NB_CTRL_WB),
    .NB_ADDRESS_REGISTROS (NB_REG),
    .NB_ADDR_MEM          (NB_ADDR_MEM)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_enable         (en),
    .i_ctrl_mem       (ctrl_mem),
    .i_ctrl_wb        (ctrl_wb),
    .i_result_alu     (alu),
    .i_write_data_mem (wdata),
    .i_write_reg      (wreg),
    .o_read_data      (o_read_data),
    .o_result_alu     (o_result_alu),
    .o_ctrl_wb        (o_ctrl_wb),
    .o_write_reg      (o_write_reg),
    .o_misaligned     (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array, little-endian, addresses wrap modulo MEM_BYTES
  logic [7:0]  mb [MEM_BYTES];
  logic [31:0] exp_rd, exp_alu;
  logic [1:0]  exp_wb;
  logic [4:0]  exp_wreg;
  logic        exp_mis;
  bit          model_valid = 1'b0;

  function automatic int nbytes_of(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  always @(posedge clk) begin : model
    logic        rd, wr, mis;
    int          nb;
    logic [11:0] base;
    logic [31:0] val;
    if (rst) begin
      exp_rd = '0; exp_alu = '0; exp_wb = '0; exp_wreg = '0; exp_mis = 1'b0;
      model_valid = 1'b1;
    end else if (en) begin
      rd   = ctrl_mem[4];
      wr   = ctrl_mem[3];
      nb   = nbytes_of(ctrl_mem[2:1]);
      base = alu[11:0];
      mis  = (rd || wr) && ((int'(alu[1:0]) % nb) != 0);
      val  = '0;
      if (rd && !mis) begin
        for (int k = 0; k < nb; k++) val = val | (32'(mb[12'(base + 12'(k))]) << (8 * k));
        if (!ctrl_mem[0] && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8 * nb)) - 32'h1);
      end
      // Read happens before the write, so a same-cycle store is not visible
      if (wr && !mis) begin
        for (int k = 0; k < nb; k++) mb[12'(base + 12'(k))] = wdata[8*k +: 8];
      end
      exp_rd = val; exp_alu = alu; exp_wb = ctrl_wb; exp_wreg = wreg; exp_mis = mis;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("read_data",  o_read_data, exp_rd);
      cmp("result_alu", o_result_alu, exp_alu);
      cmp("ctrl_wb",    32'(o_ctrl_wb), 32'(exp_wb));
      cmp("write_reg",  32'(o_write_reg), 32'(exp_wreg));
      cmp("misaligned", 32'(o_misaligned), 32'(exp_mis));
    end
  end

  task automatic step(input logic r, input logic e, input logic [4:0] c, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rg);
    rst = r; en = e; ctrl_mem = c; ctrl_wb = w; alu = a; wdata = d; wreg = rg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, c, 2'b00, a, d, 5'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ctrl_mem = C_SW; ctrl_wb = 2'b11; alu = 32'h10;
    wdata = 32'h12345678; wreg = 5'd31;

    // Reset with arbitrary (store) inputs presented
    step(1'b1, 1'b1, C_SW, 2'b11, 32'h10, 32'h12345678, 5'd31);
    step(1'b1, 1'b0, C_LW, 2'b10, 32'h24, 32'hFFFFFFFF, 5'd9);
    cmp("reset read_data",  o_read_data, 32'h0);
    cmp("reset result_alu", o_result_alu, 32'h0);
    cmp("reset ctrl_wb",    32'(o_ctrl_wb), 32'h0);
    cmp("reset write_reg",  32'(o_write_reg), 32'h0);
    cmp("reset misaligned", 32'(o_misaligned), 32'h0);

    // Give every word a known value
    for (int i = 0; i < (1 << NB_ADDR_MEM); i++) op(C_SW, 32'(i * 4), $urandom);

    op(C_SW, 32'h10, 32'hDEADBEEF);
    op(C_LW, 32'h10, 32'h0);
    cmp("lw 0x10", o_read_data, 32'hDEADBEEF);

    // Sub-word loads
    op(C_SW,  32'h20, 32'h80FF7F01);
    op(C_LB,  32'h23, 32'h0);
    cmp("lb 0x23", o_read_data, 32'hFFFFFF80);
    op(C_LBU, 32'h23, 32'h0);
    cmp("lbu 0x23", o_read_data, 32'h00000080);
    op(C_LH,  32'h22, 32'h0);
    cmp("lh 0x22", o_read_data, 32'hFFFF80FF);
    op(C_LHU, 32'h20, 32'h0);
    cmp("lhu 0x20", o_read_data, 32'h00007F01);

    // Sub-word stores
    op(C_SW, 32'h30, 32'h0);
    op(C_SB, 32'h31, 32'h000000AB);
    op(C_SH, 32'h32, 32'h00001234);
    op(C_LW, 32'h30, 32'h0);
    cmp("sb/sh merge", o_read_data, 32'h1234AB00);

    // Misalignment
    op(C_SW, 32'h40, 32'h11111111);
    op(C_SW, 32'h42, 32'hFFFFFFFF);
    cmp("sw misaligned flag", 32'(o_misaligned), 32'h1);
    op(C_LH, 32'h41, 32'h0);
    cmp("lh misaligned data", o_read_data, 32'h0);
    cmp("lh misaligned flag", 32'(o_misaligned), 32'h1);
    op(C_LW, 32'h40, 32'h0);
    cmp("lw after bad sw", o_read_data, 32'h11111111);
    cmp("lw aligned flag", 32'(o_misaligned), 32'h0);

    // Stall: outputs frozen, store ignored
    step(1'b0, 1'b1, C_SW, 2'b01, 32'h50, 32'h0A0B0C0D, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, C_SW, 2'b10, 32'h54, 32'h55, 5'd9);
      cmp("stall result_alu", o_result_alu, 32'h50);
      cmp("stall write_reg", 32'(o_write_reg), 32'd3);
    end
    op(C_LW, 32'h50, 32'h0);
    cmp("lw after stall", o_read_data, 32'h0A0B0C0D);

    // Passthrough and address wrap
    step(1'b0, 1'b1, C_NOP, 2'b10, 32'h1004, 32'h0, 5'd7);
    cmp("pass ctrl_wb", 32'(o_ctrl_wb), 32'h2);
    cmp("pass write_reg", 32'(o_write_reg), 32'd7);
    cmp("pass result_alu", o_result_alu, 32'h1004);
    op(C_SW, 32'h1004, 32'hCAFEF00D);
    op(C_LW, 32'h0004, 32'h0);
    cmp("wrap lw", o_read_data, 32'hCAFEF00D);

    // Reset drops a pending store
    op(C_SW, 32'h60, 32'h77777777);
    step(1'b1, 1'b1, C_SW, 2'b11, 32'h60, 32'h99999999, 5'd1);
    op(C_LW, 32'h60, 32'h0);
    cmp("store dropped by reset", o_read_data, 32'h77777777);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFF);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), 5'($urandom),
           2'($urandom), a, $urandom, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
